// File: rtl/ofifo_collect_pkg.sv
// Shared constants and helpers for the column-output collector.
package ofifo_collect_pkg;

  localparam int OFIFO_COL     = 8;
  localparam int OFIFO_PSUM_BW = 16;
  localparam int OFIFO_DEPTH   = 64;

  // Lane pointers carry one extra wrap bit to tell full from empty.
  function automatic int ofifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ofifo_collect_if.sv
// Bus between the array column outputs / SRAM writer and the collector.
interface ofifo_collect_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic [col-1:0]         wr;
  logic [col*psum_bw-1:0] in;
  logic                   rd;
  logic [col*psum_bw-1:0] out;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_ready;
  logic                   o_overflow;

  modport master (
    output wr, in, rd,
    input  out, o_valid, o_full, o_ready, o_overflow
  );

  modport slave (
    input  wr, in, rd,
    output out, o_valid, o_full, o_ready, o_overflow
  );
endinterface

// File: rtl/ofifo_collect_lane.sv
// Single-column first-word-fall-through FIFO with sticky overflow flag.
module ofifo_lane
  import ofifo_collect_pkg::*;
#(
  parameter int psum_bw = OFIFO_PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr,
  input  logic                      rd,
  input  logic signed [psum_bw-1:0] in,
  output logic signed [psum_bw-1:0] out,
  output logic                      o_empty,
  output logic                      o_full,
  output logic                      o_overflow
);

  localparam int PW = ofifo_ptr_w(depth);

  logic [PW-1:0]             wptr;
  logic [PW-1:0]             rptr;
  logic signed [psum_bw-1:0] mem [depth];

  assign o_empty = (wptr == rptr);
  assign o_full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[PW-2:0] == rptr[PW-2:0]);
  assign out     = mem[rptr[PW-2:0]];

  // Pointer and flag control; full/empty are judged on pre-edge pointers only.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr && !o_full) wptr <= wptr + PW'(1);
      if (wr && o_full)  o_overflow <= 1'b1;
      if (rd && !o_empty) rptr <= rptr + PW'(1);
    end
  end

  // Storage write; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (!reset && wr && !o_full) mem[wptr[PW-2:0]] <= in;
  end

endmodule

// File: rtl/ofifo_collect.sv
// Re-aligns skewed column outputs into full row words for the SRAM writer.
module ofifo_collect
  import ofifo_collect_pkg::*;
#(
  parameter int col     = OFIFO_COL,
  parameter int psum_bw = OFIFO_PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  ofifo_collect_if.slave bus
);

  logic [col-1:0]         empty;
  logic [col-1:0]         full;
  logic [col-1:0]         ovf;
  logic [col*psum_bw-1:0] lane_data;
  logic                   valid;
  logic                   pop;

  // A row exists only when every column holds data; popping is all-or-nothing.
  assign valid = &(~empty);
  assign pop   = bus.rd && valid;

  for (genvar i = 0; i < col; i++) begin : g_lane
    ofifo_lane #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .wr         (bus.wr[i]),
      .rd         (pop),
      .in         (bus.in[psum_bw*i +: psum_bw]),
      .out        (lane_data[psum_bw*i +: psum_bw]),
      .o_empty    (empty[i]),
      .o_full     (full[i]),
      .o_overflow (ovf[i])
    );
  end

  assign bus.o_valid    = valid;
  assign bus.o_full     = |full;
  assign bus.o_ready    = ~(|full);
  assign bus.o_overflow = |ovf;
  assign bus.out        = valid ? lane_data : '0;

endmodule

// File: tb/tb_ofifo_collect.sv
// Directed self-checking bench for the column-output collector.
module tb_ofifo_collect;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DEP = 64;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ofifo_collect_if #(.col(COL), .psum_bw(BW)) bus ();

  ofifo_collect #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Build a row word where lane l holds base + l*lstep.
  function automatic logic [COL*BW-1:0] row_word(input int base, input int lstep);
    logic [COL*BW-1:0] w;
    w = '0;
    for (int l = 0; l < COL; l++) w[BW*l +: BW] = 16'(base + l*lstep);
    return w;
  endfunction

  task automatic test_reset();
    reset  = 1'b1;
    bus.wr = 8'hFF;
    bus.in = row_word(16'h7700, 1);
    bus.rd = 1'b1;
    tick();
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.o_ready); end
    checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.o_full); end
    checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.o_overflow); end
    checks++; if (bus.out !== '0) begin errors++; $display("FAIL reset_out got %h want 0", bus.out); end
    reset  = 1'b0;
    bus.wr = '0;
    bus.rd = 1'b0;
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_nowrite_valid got %b want 0", bus.o_valid); end
  endtask

  task automatic test_skewed();
    logic [COL*BW-1:0] exp;
    exp = row_word(16'h1000, 1);
    for (int i = 0; i < COL; i++) begin
      bus.wr = 8'(1 << i);
      bus.in = exp;
      tick();
      if (i < COL-1) begin
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL skew_valid_early lane %0d got %b want 0", i, bus.o_valid); end
      end
    end
    bus.wr = '0;
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL skew_valid got %b want 1", bus.o_valid); end
    checks++; if (bus.out !== exp) begin errors++; $display("FAIL skew_out got %h want %h", bus.out, exp); end
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL skew_after_pop_valid got %b want 0", bus.o_valid); end
    checks++; if (bus.out !== '0) begin errors++; $display("FAIL skew_after_pop_out got %h want 0", bus.out); end
  endtask

  task automatic test_stream();
    int  pops;
    int  ignored;
    bit  seen;
    pops = 0; ignored = 0; seen = 0;
    bus.rd = 1'b1;
    for (int r = 0; r < 20; r++) begin
      bus.wr = 8'hFF;
      bus.in = row_word(r*8, 1);
      if (bus.o_valid) pops++;
      tick();
      if (bus.o_valid) seen = 1;
      checks++; if (bus.out !== row_word(r*8, 1)) begin errors++; $display("FAIL stream_row %0d got %h want %h", r, bus.out, row_word(r*8, 1)); end
    end
    bus.wr = '0;
    for (int k = 0; k < 3; k++) begin
      if (bus.o_valid) pops++;
      else if (seen) ignored++;
      tick();
    end
    bus.rd = 1'b0;
    // Only the trailing idle cycles after the last pop may see rd with no data.
    checks++; if (pops !== 20) begin errors++; $display("FAIL stream_pops got %0d want 20", pops); end
    checks++; if (ignored !== 2) begin errors++; $display("FAIL stream_tail_ignored got %0d want 2", ignored); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid got %b want 0", bus.o_valid); end
  endtask

  task automatic test_overflow();
    logic [COL*BW-1:0] w;
    for (int k = 0; k < DEP; k++) begin
      bus.wr = 8'h08;
      bus.in = row_word(16'h3000 + k, 0);
      tick();
    end
    checks++; if (bus.o_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", bus.o_full); end
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got %b want 0", bus.o_ready); end
    checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", bus.o_overflow); end
    bus.in = row_word(16'hDEAD, 0);
    tick();
    checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", bus.o_overflow); end
    for (int k = 0; k < DEP; k++) begin
      bus.wr = 8'hF7;
      bus.in = row_word(16'h4000 + k, 0);
      tick();
    end
    bus.wr = '0;
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL ovf_all_valid got %b want 1", bus.o_valid); end
    bus.rd = 1'b1;
    for (int k = 0; k < DEP; k++) begin
      w = bus.out;
      checks++; if (w[BW*3 +: BW] !== 16'(16'h3000 + k)) begin errors++; $display("FAIL ovf_drain %0d got %h want %h", k, w[BW*3 +: BW], 16'(16'h3000 + k)); end
      tick();
    end
    bus.rd = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained_valid got %b want 0", bus.o_valid); end
    checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", bus.o_overflow); end
  endtask

  task automatic test_wrap();
    for (int it = 0; it < 3; it++) begin
      bus.rd = 1'b0;
      for (int k = 0; k < DEP; k++) begin
        bus.wr = 8'hFF;
        bus.in = row_word(16'h8000 + it*16'h0100 + k, 16'h1000);
        tick();
      end
      bus.wr = '0;
      checks++; if (bus.o_full !== 1'b1) begin errors++; $display("FAIL wrap_full it %0d got %b want 1", it, bus.o_full); end
      bus.rd = 1'b1;
      for (int k = 0; k < DEP; k++) begin
        checks++; if (bus.out !== row_word(16'h8000 + it*16'h0100 + k, 16'h1000)) begin errors++; $display("FAIL wrap_data it %0d k %0d got %h want %h", it, k, bus.out, row_word(16'h8000 + it*16'h0100 + k, 16'h1000)); end
        tick();
      end
      bus.rd = 1'b0;
      checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty it %0d got %b want 0", it, bus.o_valid); end
      checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL wrap_notfull it %0d got %b want 0", it, bus.o_full); end
    end
  endtask

  task automatic test_mid_reset();
    for (int r = 0; r < 10; r++) begin
      bus.wr = 8'hFF;
      bus.in = row_word(16'h2000 + r, 0);
      tick();
    end
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", bus.o_valid); end
    reset  = 1'b1;
    bus.wr = 8'hFF;
    bus.rd = 1'b1;
    tick();
    reset  = 1'b0;
    bus.wr = '0;
    bus.rd = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", bus.o_valid); end
    checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b want 0", bus.o_overflow); end
    checks++; if (bus.out !== '0) begin errors++; $display("FAIL mid_out got %h want 0", bus.out); end
    bus.wr = 8'hFF;
    bus.in = row_word(16'h5A00, 1);
    tick();
    bus.wr = '0;
    checks++; if (bus.out !== row_word(16'h5A00, 1)) begin errors++; $display("FAIL mid_new_out got %h want %h", bus.out, row_word(16'h5A00, 1)); end
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL mid_final_valid got %b want 0", bus.o_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.wr = '0;
    bus.in = '0;
    bus.rd = 1'b0;
    test_reset();
    test_skewed();
    test_stream();
    test_overflow();
    test_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
